// File: rtl/add_rnd_sat_pipe_if.sv
// Handshake bundle for add_rnd_sat_pipe: input stream, output stream and saturation diagnostics.
// slave = pipeline side, master = producer/consumer side.
interface add_rnd_sat_pipe_if #(
  parameter int unsigned IW    = 14,
  parameter int unsigned DW    = 13,
  parameter int unsigned CNT_W = 16
);
  logic [IW-1:0]    din;
  logic             din_valid;
  logic             din_ready;
  logic [DW-1:0]    dout;
  logic             dout_valid;
  logic             dout_ready;
  logic             dout_sat;
  logic             dout_last;
  logic             sat_clr;
  logic [CNT_W-1:0] sat_cnt;

  modport slave (
    input  din, din_valid, dout_ready, sat_clr,
    output din_ready, dout, dout_valid, dout_sat, dout_last, sat_cnt
  );

  modport master (
    output din, din_valid, dout_ready, sat_clr,
    input  din_ready, dout, dout_valid, dout_sat, dout_last, sat_cnt
  );
endinterface

// File: rtl/add_rnd_sat_pipe.sv
// Requantizes the DW+1 bit butterfly sum to DW bits: round off SHIFT LSBs, then saturate.
// Define ADD_RND_CONVERGENT_EN to switch ties from half-up to half-to-even rounding.
module add_rnd_sat_pipe #(
  parameter int unsigned SIGN_BIT  = 1,
  parameter int unsigned INT_BIT   = 6,
  parameter int unsigned FLT_BIT   = 6,
  parameter int unsigned SHIFT     = 1,
  parameter int unsigned FRAME_LEN = 27,
  parameter int unsigned CNT_W     = 16
) (
  input logic              clk,
  input logic              rst,
  add_rnd_sat_pipe_if.slave bus
);

  localparam int unsigned DW = SIGN_BIT + INT_BIT + FLT_BIT;
  localparam int unsigned IW = DW + 1;
  localparam int unsigned XW = IW + 1;
  localparam int unsigned FW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

  localparam logic signed [XW-1:0] MAX_V    = XW'((1 << (DW - 1)) - 1);
  localparam logic signed [XW-1:0] MIN_V    = XW'(-(1 << (DW - 1)));
  localparam logic        [FW-1:0] LAST_IDX = FW'(FRAME_LEN - 1);

  logic [XW-1:0] ext_c;
  logic [XW-1:0] s1_d_c;
  logic [XW-1:0] s1_data;
  logic          s1_valid;
  logic          s1_adv_c;
  logic          s2_adv_c;
  logic          in_xfer_c;
  logic          out_xfer_c;
  logic          sat_c;
  logic [DW-1:0] clip_c;
  // Frame index of the next sample to enter the output register.
  logic [FW-1:0] frame_cnt;

  assign ext_c      = {bus.din[IW-1], bus.din};
  assign s2_adv_c   = !bus.dout_valid || bus.dout_ready;
  assign s1_adv_c   = !s1_valid || s2_adv_c;
  assign bus.din_ready = s1_adv_c && !rst;
  assign in_xfer_c  = bus.din_valid && bus.din_ready;
  assign out_xfer_c = bus.dout_valid && bus.dout_ready;

  // Rounding: one extra headroom bit keeps the add from overflowing.
  if (SHIFT == 0) begin : g_noshift
    assign s1_d_c = ext_c;
  end else begin : g_shift
    localparam logic [XW-1:0] HALF = XW'(1) << (SHIFT - 1);
    logic [XW-1:0] rnd_c;
    logic [XW-1:0] sum_c;
`ifdef ADD_RND_CONVERGENT_EN
    logic tie_even_c;
    assign tie_even_c = (bus.din[SHIFT-1:0] == HALF[SHIFT-1:0]) && !bus.din[SHIFT];
    assign rnd_c      = tie_even_c ? '0 : HALF;
`else
    assign rnd_c = HALF;
`endif
    assign sum_c  = ext_c + rnd_c;
    assign s1_d_c = XW'($signed(sum_c) >>> SHIFT);
  end

  // Clamp the rounded value to the DW-bit signed range.
  always_comb begin
    sat_c  = 1'b0;
    clip_c = s1_data[DW-1:0];
    if ($signed(s1_data) > MAX_V) begin
      sat_c  = 1'b1;
      clip_c = MAX_V[DW-1:0];
    end else if ($signed(s1_data) < MIN_V) begin
      sat_c  = 1'b1;
      clip_c = MIN_V[DW-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid       <= 1'b0;
      s1_data        <= '0;
      bus.dout_valid <= 1'b0;
      bus.dout       <= '0;
      bus.dout_sat   <= 1'b0;
      bus.dout_last  <= 1'b0;
      frame_cnt      <= '0;
      bus.sat_cnt    <= '0;
    end else begin
      if (s1_adv_c) begin
        s1_valid <= in_xfer_c;
        if (in_xfer_c) begin
          s1_data <= s1_d_c;
        end
      end

      // Samples load into the output register in order, so the load index is the frame index.
      if (s2_adv_c) begin
        bus.dout_valid <= s1_valid;
        if (s1_valid) begin
          bus.dout      <= clip_c;
          bus.dout_sat  <= sat_c;
          bus.dout_last <= (frame_cnt == LAST_IDX);
          frame_cnt     <= (frame_cnt == LAST_IDX) ? '0 : frame_cnt + FW'(1);
        end else begin
          bus.dout_last <= 1'b0;
        end
      end

      if (bus.sat_clr) begin
        bus.sat_cnt <= '0;
      end else if (out_xfer_c && bus.dout_sat && !(&bus.sat_cnt)) begin
        bus.sat_cnt <= bus.sat_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_add_rnd_sat_pipe.sv
// Self-checking bench for add_rnd_sat_pipe against an integer round+saturate reference model.
module tb_add_rnd_sat_pipe;

  localparam int unsigned SIGN_BIT  = 1;
  localparam int unsigned INT_BIT   = 6;
  localparam int unsigned FLT_BIT   = 6;
  localparam int unsigned SHIFT     = 1;
  localparam int unsigned FRAME_LEN = 27;
  localparam int unsigned CNT_W     = 16;
  localparam int unsigned DW        = SIGN_BIT + INT_BIT + FLT_BIT;
  localparam int unsigned IW        = DW + 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  add_rnd_sat_pipe_if #(.IW(IW), .DW(DW), .CNT_W(CNT_W)) bus ();

  add_rnd_sat_pipe #(
    .SIGN_BIT(SIGN_BIT), .INT_BIT(INT_BIT), .FLT_BIT(FLT_BIT),
    .SHIFT(SHIFT), .FRAME_LEN(FRAME_LEN), .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  logic [IW-1:0] src_q[$];
  logic [IW-1:0] sent_q[$];
  logic [DW-1:0] got_d[$];
  logic          got_s[$];
  logic          got_l[$];

  // Reference: real-valued rounding of v / 2^SHIFT, then clip to the DW-bit signed range.
  function automatic void ref_model(input logic [IW-1:0] d, output logic [DW-1:0] q, output logic s);
    int v, r, half, rem, fl, maxv, minv;
    v    = int'($signed(d));
    half = (SHIFT > 0) ? (1 << (SHIFT - 1)) : 0;
    if (SHIFT == 0) begin
      r = v;
    end else begin
      rem = v & ((1 << SHIFT) - 1);
      fl  = v >>> SHIFT;
`ifdef ADD_RND_CONVERGENT_EN
      if (rem == half && (fl & 1) == 0) r = fl;
      else r = (v + half) >>> SHIFT;
`else
      r = (v + half) >>> SHIFT;
`endif
    end
    maxv = (1 << (DW - 1)) - 1;
    minv = -(1 << (DW - 1));
    s = 1'b0;
    if (r > maxv) begin r = maxv; s = 1'b1; end
    else if (r < minv) begin r = minv; s = 1'b1; end
    q = DW'(r);
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.din_valid  = 1'b0;
    bus.sat_clr    = 1'b0;
    bus.dout_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Drives src_q with random valid/ready until target outputs are collected (no checking here).
  task automatic run_stream(input int target, input int vprob, input int rprob, input int max_cyc);
    int cyc;
    got_d.delete(); got_s.delete(); got_l.delete(); sent_q.delete();
    cyc = 0;
    while (got_d.size() < target && cyc < max_cyc) begin
      @(negedge clk);
      cyc++;
      bus.din_valid  = (src_q.size() > 0) && ($urandom_range(99) < vprob);
      bus.din        = (src_q.size() > 0) ? src_q[0] : IW'($urandom);
      bus.dout_ready = ($urandom_range(99) < rprob);
      #1;
      if (bus.din_valid && bus.din_ready) sent_q.push_back(src_q.pop_front());
      if (bus.dout_valid && bus.dout_ready) begin
        got_d.push_back(bus.dout);
        got_s.push_back(bus.dout_sat);
        got_l.push_back(bus.dout_last);
      end
    end
    @(posedge clk);
    #1;
    bus.din_valid  = 1'b0;
    bus.dout_ready = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.din = IW'(3);
    bus.din_valid = 1'b1;
    bus.dout_ready = 1'b1;
    bus.sat_clr = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (bus.din_ready !== 1'b0) begin errors++; $display("FAIL reset_din_ready got %b exp 0", bus.din_ready); end
    checks++; if (bus.dout_valid !== 1'b0) begin errors++; $display("FAIL reset_dout_valid got %b exp 0", bus.dout_valid); end
    checks++; if (bus.dout !== '0) begin errors++; $display("FAIL reset_dout got %0h exp 0", bus.dout); end
    checks++; if (bus.dout_sat !== 1'b0 || bus.dout_last !== 1'b0) begin errors++; $display("FAIL reset_flags got sat=%b last=%b exp 0 0", bus.dout_sat, bus.dout_last); end
    checks++; if (bus.sat_cnt !== '0) begin errors++; $display("FAIL reset_sat_cnt got %0d exp 0", bus.sat_cnt); end
    bus.din_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    #1;
    checks++; if (bus.dout_valid !== 1'b0 || bus.sat_cnt !== '0) begin errors++; $display("FAIL post_reset got valid=%b cnt=%0d exp 0 0", bus.dout_valid, bus.sat_cnt); end
    checks++; if (bus.din_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready got %b exp 1", bus.din_ready); end
  endtask

  task automatic test_directed();
    int vals[10] = '{3, -3, 1, 8191, -8192, 0, -1, 8190, -8191, 100};
    int lat, nsat;
    logic [DW-1:0] eq;
    logic es;
    nsat = 0;
    for (int i = 0; i < 10; i++) begin
      ref_model(IW'(vals[i]), eq, es);
      if (es) nsat++;
      @(negedge clk);
      bus.din = IW'(vals[i]);
      bus.din_valid = 1'b1;
      bus.dout_ready = 1'b1;
      #1;
      checks++; if (bus.din_ready !== 1'b1) begin errors++; $display("FAIL dir_ready[%0d] got %b exp 1", i, bus.din_ready); end
      lat = 0;
      do begin
        @(posedge clk);
        lat++;
        #1;
        bus.din_valid = 1'b0;
      end while (!bus.dout_valid && lat < 8);
      checks++; if (lat !== 2) begin errors++; $display("FAIL dir_latency[%0d] got %0d exp 2", i, lat); end
      checks++; if (bus.dout !== eq || bus.dout_sat !== es) begin errors++; $display("FAIL dir_value din=%0d got %0h/%b exp %0h/%b", vals[i], bus.dout, bus.dout_sat, eq, es); end
    end
    @(posedge clk);
    #1;
    checks++; if (bus.sat_cnt !== CNT_W'(nsat)) begin errors++; $display("FAIL dir_sat_cnt got %0d exp %0d", bus.sat_cnt, nsat); end
  endtask

  task automatic test_sat_clr();
    int lat;
    int exp_cnt[3] = '{1, 0, 1};
    do_reset();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      bus.din = IW'(8191);
      bus.din_valid = 1'b1;
      bus.dout_ready = 1'b1;
      lat = 0;
      do begin
        @(negedge clk);
        lat++;
        bus.din_valid = 1'b0;
      end while (!bus.dout_valid && lat < 8);
      checks++; if (bus.dout !== DW'(4095) || bus.dout_sat !== 1'b1) begin errors++; $display("FAIL clr_value[%0d] got %0h/%b exp fff/1", k, bus.dout, bus.dout_sat); end
      bus.sat_clr = (k == 1);
      @(negedge clk);
      bus.sat_clr = 1'b0;
      checks++; if (bus.sat_cnt !== CNT_W'(exp_cnt[k])) begin errors++; $display("FAIL clr_cnt[%0d] got %0d exp %0d", k, bus.sat_cnt, exp_cnt[k]); end
    end
  endtask

  task automatic test_backpressure();
    int cyc, stalls;
    bit saw_nr;
    logic [DW-1:0] hold_d, eq;
    logic hold_s, hold_l, es;
    do_reset();
    src_q.delete(); got_d.delete(); got_s.delete(); got_l.delete();
    for (int i = 0; i < 10; i++) src_q.push_back(IW'(i));
    cyc = 0; stalls = 0; saw_nr = 1'b0;
    hold_d = '0; hold_s = 1'b0; hold_l = 1'b0;
    while (got_d.size() < 10 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      bus.din_valid = src_q.size() > 0;
      bus.din = (src_q.size() > 0) ? src_q[0] : '0;
      #1;
      if (bus.dout_valid && stalls < 5) begin
        if (stalls == 0) begin
          hold_d = bus.dout; hold_s = bus.dout_sat; hold_l = bus.dout_last;
        end else begin
          checks++;
          if (bus.dout !== hold_d || bus.dout_sat !== hold_s || bus.dout_last !== hold_l) begin
            errors++; $display("FAIL bp_hold cyc %0d got %0h exp %0h", cyc, bus.dout, hold_d);
          end
        end
        bus.dout_ready = 1'b0;
        stalls++;
      end else begin
        bus.dout_ready = 1'b1;
      end
      #1;
      if (!bus.din_ready) saw_nr = 1'b1;
      if (bus.din_valid && bus.din_ready) void'(src_q.pop_front());
      if (bus.dout_valid && bus.dout_ready) begin
        got_d.push_back(bus.dout);
        got_s.push_back(bus.dout_sat);
      end
    end
    @(posedge clk);
    #1;
    bus.din_valid = 1'b0;
    checks++; if (saw_nr !== 1'b1) begin errors++; $display("FAIL bp_ready_drop got %b exp 1", saw_nr); end
    checks++; if (got_d.size() !== 10) begin errors++; $display("FAIL bp_count got %0d exp 10", got_d.size()); end
    for (int i = 0; i < got_d.size(); i++) begin
      ref_model(IW'(i), eq, es);
      checks++; if (got_d[i] !== eq) begin errors++; $display("FAIL bp_order[%0d] got %0h exp %0h", i, got_d[i], eq); end
    end
  endtask

  task automatic test_framing();
    logic [DW-1:0] eq;
    logic es;
    do_reset();
    src_q.delete();
    for (int i = 0; i < 60; i++) src_q.push_back(IW'($urandom));
    run_stream(60, 100, 100, 400);
    checks++; if (got_l.size() !== 60) begin errors++; $display("FAIL frame_count got %0d exp 60", got_l.size()); end
    for (int i = 0; i < got_l.size(); i++) begin
      checks++; if (got_l[i] !== ((i == 26) || (i == 53))) begin errors++; $display("FAIL frame_last[%0d] got %b exp %b", i, got_l[i], (i == 26) || (i == 53)); end
    end
    // Interrupt a stream mid-frame with samples still in flight.
    src_q.delete();
    for (int i = 0; i < 15; i++) src_q.push_back(IW'($urandom));
    run_stream(10, 100, 100, 200);
    do_reset();
    src_q.delete();
    #1;
    checks++; if (bus.dout_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_valid got %b exp 0", bus.dout_valid); end
    for (int i = 0; i < 27; i++) src_q.push_back(IW'($urandom));
    run_stream(27, 100, 100, 200);
    checks++; if (got_d.size() !== 27 || sent_q.size() !== 27) begin errors++; $display("FAIL mid_reset_count got %0d exp 27", got_d.size()); end
    for (int i = 0; i < got_d.size() && i < sent_q.size(); i++) begin
      ref_model(sent_q[i], eq, es);
      checks++; if (got_d[i] !== eq || got_l[i] !== (i == 26)) begin errors++; $display("FAIL mid_reset_out[%0d] got %0h/%b exp %0h/%b", i, got_d[i], got_l[i], eq, i == 26); end
    end
  endtask

  task automatic test_random();
    int nsat, bad;
    logic [DW-1:0] eq;
    logic es;
    do_reset();
    src_q.delete();
    for (int i = 0; i < 10000; i++) src_q.push_back(IW'($urandom));
    run_stream(10000, 70, 70, 60000);
    checks++; if (got_d.size() !== 10000 || sent_q.size() !== 10000) begin errors++; $display("FAIL rand_count got %0d exp 10000", got_d.size()); end
    nsat = 0; bad = 0;
    for (int i = 0; i < got_d.size() && i < sent_q.size(); i++) begin
      ref_model(sent_q[i], eq, es);
      if (es) nsat++;
      checks++;
      if (got_d[i] !== eq || got_s[i] !== es || got_l[i] !== ((i % FRAME_LEN) == FRAME_LEN - 1)) begin
        errors++; bad++;
        if (bad <= 10) $display("FAIL rand_out[%0d] din=%0h got %0h/%b/%b exp %0h/%b/%b", i, sent_q[i], got_d[i], got_s[i], got_l[i], eq, es, (i % FRAME_LEN) == FRAME_LEN - 1);
      end
    end
    checks++; if (bus.sat_cnt !== CNT_W'(nsat)) begin errors++; $display("FAIL rand_sat_cnt got %0d exp %0d", bus.sat_cnt, nsat); end
  endtask

  initial begin
    rst = 1'b1;
    bus.din = '0;
    bus.din_valid = 1'b0;
    bus.dout_ready = 1'b1;
    bus.sat_clr = 1'b0;
    test_reset();
    test_directed();
    test_reset();
    test_sat_clr();
    test_backpressure();
    test_framing();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/add_rnd_sat_pipe.md
Name: add_rnd_sat_pipe

Overview:
- Consumes the grown-width (DW+1) sum produced by the radix-3 butterfly adders and requantizes it back to DW bits.
- Drops SHIFT LSBs with rounding, then saturates to DW-bit signed.
- Two-stage valid/ready pipeline with frame tagging and a saturation event counter for scaling diagnostics.

Parameters:
- SIGN_BIT, 1, sign bits of output format
- INT_BIT, 6, integer bits of output format
- FLT_BIT, 6, fraction bits of output format
- SHIFT, 1, LSBs discarded before saturation (0..3); 0 = saturate only
- FRAME_LEN, 27, samples per FFT frame (>=2)
- CNT_W, 16, saturation counter width
- Derived: DW = SIGN_BIT+INT_BIT+FLT_BIT; IW = DW+1

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- din  in  IW  two's-complement sum from adder stage
- din_valid  in  1  din qualifier
- din_ready  out  1  stage can accept din this cycle
- dout  out  DW  requantized sample
- dout_valid  out  1  dout qualifier
- dout_ready  in  1  downstream accepts dout
- dout_sat  out  1  this dout was clipped
- dout_last  out  1  dout is final sample of frame
- sat_clr  in  1  clear sat_cnt
- sat_cnt  out  CNT_W  saturated samples accepted since last clear

Behaviour:
- Clock/reset: one clock `clk`; reset `rst` is synchronous and active-high. While rst=1 and on the cycle after: s1/s2 empty, dout_valid=0, dout=0, dout_sat=0, dout_last=0, sat_cnt=0, frame counter=0, din_ready=0 during rst.
- Transfer rules: input transfer when din_valid&&din_ready; output transfer when dout_valid&&dout_ready.
- Stage 1: sign-extend din to IW+1 bits, add 2^(SHIFT-1) (nothing if SHIFT=0), arithmetic shift right by SHIFT, and register it with s1_valid.
- Stage 2: compare the stage-1 value against [-2^(DW-1), 2^(DW-1)-1].
  - Clamp to the nearest bound if outside and set sat.
  - Register into dout/dout_sat, with dout_valid = s2_valid.
- Advance rules:
  - s2_adv = !s2_valid || dout_ready.
  - s1_adv = !s1_valid || s2_adv.
  - din_ready = s1_adv && !rst (combinational).
- Latency and throughput: latency is exactly 2 cycles from input transfer to dout_valid when unstalled. Throughput is 1 sample/cycle.
- Bubbles: a bubble in s1 is collapsed (s2 is filled from s1 only when s1_valid).
- Stall: when stalled, dout, dout_sat, dout_last and dout_valid hold stable until transfer. No sample is dropped or duplicated, and order is preserved.
- Frame counter: range 0..FRAME_LEN-1, increments on each output transfer and wraps to 0 after FRAME_LEN-1. dout_last = (counter==FRAME_LEN-1) && dout_valid.
- sat_cnt:
  - Increments on each output transfer with dout_sat=1.
  - Sticks at all-ones (no wrap).
  - sat_clr has priority: if sat_clr and an increment occur in the same cycle, the result is 0.
- Reset mid-operation: in-flight samples are discarded and the frame counter returns to 0. The next accepted sample is frame sample 0.
- Overflow: no internal overflow is possible; the stage-1 intermediate is IW+1 bits.

Optional Feature:
- Macro: ADD_RND_CONVERGENT_EN.
- Defined: round-half-to-even. When the discarded bits equal exactly 2^(SHIFT-1), add 2^(SHIFT-1) only if the retained LSB is 1; otherwise use half-up as above.
- Undefined: always round-half-up (add 2^(SHIFT-1) then floor shift).
- No effect when SHIFT=0.
- Ports, latency and saturation are identical in both builds.

Test Plan:
- Defaults (DW=13, IW=14, SHIFT=1), dout_ready=1:
  - din=3 -> dout=2 (0x0002) two cycles later, dout_sat=0.
  - din=-3 (0x3FFD) -> dout=-1 (0x1FFF).
  - din=1 -> dout=1 (half-up), or 0 with ADD_RND_CONVERGENT_EN; din=3 -> 2 in both builds.
- Saturation: din=8191 (0x1FFF) -> dout=4095 (0x0FFF), dout_sat=1, sat_cnt=1.
  - din=-8192 (0x2000) -> dout=-4096 (0x1000), dout_sat=0.
  - Assert sat_clr on a cycle with a saturating transfer -> sat_cnt=0.
- Backpressure: stream 0..9 continuously, hold dout_ready=0 for 5 cycles after first dout_valid.
  - din_ready falls once both stages are full.
  - dout is held stable while stalled.
  - After release, outputs are the rounded values of 0..9 in order, no loss.
- Framing: stream 60 samples -> dout_last on output transfers 27 and 54 only.
  - Assert rst after the 10th output, then stream 27 -> dout_last on the 27th post-reset sample.
- Random: 10k random din with random valid/ready -> every output matches the golden round+saturate model; sat_cnt equals the count of clipped samples.
